regfile_2r1w: RTL and testbench

Parametrised multi-port register file. Provides two independent registered read ports and one write port, all of which can be used in the same cycle. Supports configurable write-to-read bypass, per-register read-only protection, and out-of-range address detection. Sits between the pipeline decode/writeback stages and the operand muxes, and exposes all register contents on a flat debug bus.

---
 rtl/regfile_2r1w.sv | 128 ++++++++++++
 tb/tb_regfile_2r1w.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w.sv
// Two-read / one-write register file with optional write-to-read forwarding,
// per-register write protection and out-of-range address handling.
module regfile_2r1w #(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      DEPTH   = 8,
  parameter int unsigned      ADDR    = 3,
  parameter bit               BYPASS  = 1'b1,
  parameter logic [DEPTH-1:0] RO_MASK = '0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   WrEn,
  input  logic [ADDR-1:0]        WrAddr,
  input  logic [WIDTH-1:0]       WrData,
  input  logic                   RdEnA,
  input  logic [ADDR-1:0]        RdAddrA,
  output logic [WIDTH-1:0]       RdDataA,
  output logic                   RdDataA_VLD,
  input  logic                   RdEnB,
  input  logic [ADDR-1:0]        RdAddrB,
  output logic [WIDTH-1:0]       RdDataB,
  output logic                   RdDataB_VLD,
  output logic                   WrErr,
  output logic [WIDTH*DEPTH-1:0] REGS
);

  localparam int unsigned SLOTS = 1 << ADDR;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];

  // Every encodable address gets a slot; slots past DEPTH read as zero and
  // never accept a write, so lookups need no separate range compare.
  logic [SLOTS-1:0] wr_ok;
  logic [WIDTH-1:0] rd_view [SLOTS];
  logic             wr_accept;
  logic             wr_err_q;

  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
      if (gi < DEPTH) begin : g_live
        assign wr_ok[gi]   = ~RO_MASK[gi];
        assign rd_view[gi] = regs_q[gi];
      end else begin : g_hole
        assign wr_ok[gi]   = 1'b0;
        assign rd_view[gi] = '0;
      end
    end
  endgenerate

  assign wr_accept = WrEn & wr_ok[WrAddr];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_accept && (WrAddr == ADDR'(i))) begin
        regs_d[i] = WrData;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= (i == DEPTH - 1) ? '1 : '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= WrEn & ~wr_accept;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
      assign REGS[gi*WIDTH +: WIDTH] = regs_q[gi];
    end
  endgenerate

  // Read ports are identical; index 0 is port A, index 1 is port B.
  logic            rd_en   [2];
  logic [ADDR-1:0] rd_addr [2];

  assign rd_en[0]   = RdEnA;
  assign rd_en[1]   = RdEnB;
  assign rd_addr[0] = RdAddrA;
  assign rd_addr[1] = RdAddrB;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic [WIDTH-1:0] data_d;
      logic [WIDTH-1:0] data_q;
      logic             vld_q;
      logic             hit;

      // Only accepted writes can hit, so rejected data is never forwarded.
      assign hit    = BYPASS && wr_accept && (rd_addr[gi] == WrAddr);
      assign data_d = hit ? WrData : rd_view[rd_addr[gi]];

      always_ff @(posedge CLK) begin
        if (RST) begin
          data_q <= '0;
          vld_q  <= 1'b0;
        end else begin
          vld_q <= rd_en[gi];
          if (rd_en[gi]) begin
            data_q <= data_d;
          end
        end
      end
    end
  endgenerate

  assign RdDataA     = g_port[0].data_q;
  assign RdDataA_VLD = g_port[0].vld_q;
  assign RdDataB     = g_port[1].data_q;
  assign RdDataB_VLD = g_port[1].vld_q;
  assign WrErr       = wr_err_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Drives two register-file variants with shared stimulus and checks both
// against an array-based model every cycle, plus directed literal checks.
module tb_regfile_2r1w;
  logic       clk;
  logic       rst;
  logic       we;
  logic [2:0] wa;
  logic [7:0] wd;
  logic       rea, reb;
  logic [2:0] raa, rab;

  logic [7:0]  rda0, rdb0, rda1, rdb1;
  logic        va0, vb0, va1, vb1, err0, err1;
  logic [63:0] regs0;
  logic [47:0] regs1;

  int tests = 0;
  int fails = 0;

  // Variant 0: 8 regs, forwarding, reg 0 protected.
  // Variant 1: 6 regs, no forwarding, reg 3 protected.
  int         dep [2] = '{8, 6};
  int         byp [2] = '{1, 0};
  logic [7:0] rom [2] = '{8'h01, 8'h08};

  logic [7:0] m     [2][8];
  logic [7:0] e_rda [2];
  logic [7:0] e_rdb [2];
  logic       e_va  [2];
  logic       e_vb  [2];
  logic       e_err [2];

  regfile_2r1w #(.WIDTH(8), .DEPTH(8), .ADDR(3), .BYPASS(1'b1), .RO_MASK(8'b0000_0001)) u_dut0 (
    .CLK(clk), .RST(rst), .WrEn(we), .WrAddr(wa), .WrData(wd),
    .RdEnA(rea), .RdAddrA(raa), .RdDataA(rda0), .RdDataA_VLD(va0),
    .RdEnB(reb), .RdAddrB(rab), .RdDataB(rdb0), .RdDataB_VLD(vb0),
    .WrErr(err0), .REGS(regs0)
  );

  regfile_2r1w #(.WIDTH(8), .DEPTH(6), .ADDR(3), .BYPASS(1'b0), .RO_MASK(6'b001000)) u_dut1 (
    .CLK(clk), .RST(rst), .WrEn(we), .WrAddr(wa), .WrData(wd),
    .RdEnA(rea), .RdAddrA(raa), .RdDataA(rda1), .RdDataA_VLD(va1),
    .RdEnB(reb), .RdAddrB(rab), .RdDataB(rdb1), .RdDataB_VLD(vb1),
    .WrErr(err1), .REGS(regs1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  // Model word seen by a read issued this cycle.
  function automatic logic [7:0] model_read(input int k, input logic [2:0] ra, input bit acc);
    if (acc && byp[k] == 1 && ra == wa) return wd;
    if (int'(ra) < dep[k]) return m[k][ra];
    return 8'h00;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int i = 0; i < 8; i++) m[k][i] = (i == dep[k] - 1) ? 8'hFF : 8'h00;
        e_rda[k] = 8'h00; e_rdb[k] = 8'h00;
        e_va[k] = 1'b0; e_vb[k] = 1'b0; e_err[k] = 1'b0;
      end else begin
        bit acc;
        acc = we && (int'(wa) < dep[k]) && !rom[k][wa];
        e_va[k] = rea;
        e_vb[k] = reb;
        if (rea) e_rda[k] = model_read(k, raa, acc);
        if (reb) e_rdb[k] = model_read(k, rab, acc);
        e_err[k] = we && !acc;
        if (acc) m[k][wa] = wd;
      end
    end
  endtask

  task automatic compare();
    logic [63:0] g_regs, x_regs;
    logic [7:0]  g_rda, g_rdb;
    logic        g_va, g_vb, g_err;
    for (int k = 0; k < 2; k++) begin
      g_regs = (k == 0) ? regs0 : {16'h0, regs1};
      g_rda  = (k == 0) ? rda0 : rda1;
      g_rdb  = (k == 0) ? rdb0 : rdb1;
      g_va   = (k == 0) ? va0 : va1;
      g_vb   = (k == 0) ? vb0 : vb1;
      g_err  = (k == 0) ? err0 : err1;
      x_regs = '0;
      for (int i = 0; i < dep[k]; i++) x_regs[i*8 +: 8] = m[k][i];
      chk($sformatf("i%0d_regs", k), g_regs, x_regs);
      chk($sformatf("i%0d_vld_a", k), 64'(g_va), 64'(e_va[k]));
      chk($sformatf("i%0d_vld_b", k), 64'(g_vb), 64'(e_vb[k]));
      chk($sformatf("i%0d_rd_a", k), 64'(g_rda), 64'(e_rda[k]));
      chk($sformatf("i%0d_rd_b", k), 64'(g_rdb), 64'(e_rdb[k]));
      chk($sformatf("i%0d_wrerr", k), 64'(g_err), 64'(e_err[k]));
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic idle();
    rst = 1'b0; we = 1'b0; rea = 1'b0; reb = 1'b0;
    wa = '0; wd = '0; raa = '0; rab = '0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    cycle();
    cycle();
    chk("lit_reset_regs0", regs0, 64'hFF00_0000_0000_0000);
    chk("lit_reset_regs1", {16'h0, regs1}, 64'h0000_FF00_0000_0000);
    chk("lit_reset_vld", {62'h0, va0, vb0}, 64'h0);
    chk("lit_reset_err", {62'h0, err0, err1}, 64'h0);

    idle(); rea = 1'b1; raa = 3'd7;
    cycle();
    chk("lit_read7_a0", {55'h0, va0, rda0}, 64'h1FF);

    idle(); we = 1'b1; wa = 3'd2; wd = 8'h3C;
    cycle();
    idle(); we = 1'b1; wa = 3'd5; wd = 8'hA5;
    cycle();
    idle(); rea = 1'b1; raa = 3'd2; reb = 1'b1; rab = 3'd5;
    cycle();
    chk("lit_dual_a0", {55'h0, va0, rda0}, 64'h13C);
    chk("lit_dual_b0", {55'h0, vb0, rdb0}, 64'h1A5);
    idle();
    cycle();
    chk("lit_hold_a0", {55'h0, va0, rda0}, 64'h03C);

    idle(); we = 1'b1; wa = 3'd4; wd = 8'h5A; rea = 1'b1; raa = 3'd4;
    cycle();
    chk("lit_coll_byp1", 64'(rda0), 64'h5A);
    chk("lit_coll_byp0", 64'(rda1), 64'h00);
    idle(); rea = 1'b1; raa = 3'd4;
    cycle();
    chk("lit_after_coll_byp0", 64'(rda1), 64'h5A);

    idle(); we = 1'b1; wa = 3'd0; wd = 8'h77; rea = 1'b1; raa = 3'd0;
    cycle();
    chk("lit_ro_err", 64'(err0), 64'h1);
    chk("lit_ro_no_fwd", 64'(rda0), 64'h00);
    idle();
    cycle();
    chk("lit_ro_err_pulse", 64'(err0), 64'h0);
    chk("lit_ro_reg0", 64'(regs0[7:0]), 64'h00);

    idle(); we = 1'b1; wa = 3'd7; wd = 8'h99; rea = 1'b1; raa = 3'd6;
    cycle();
    chk("lit_range_err", 64'(err1), 64'h1);
    chk("lit_range_rd6", {55'h0, va1, rda1}, 64'h100);

    idle(); rst = 1'b1; we = 1'b1; wa = 3'd1; wd = 8'h11;
    rea = 1'b1; raa = 3'd2; reb = 1'b1; rab = 3'd5;
    cycle();
    chk("lit_midrst_regs0", regs0, 64'hFF00_0000_0000_0000);
    chk("lit_midrst_out", {46'h0, va0, vb0, rda0, rdb0}, 64'h0);
    idle(); we = 1'b1; wa = 3'd1; wd = 8'h11;
    cycle();
    idle(); rea = 1'b1; raa = 3'd1;
    cycle();
    chk("lit_resume", 64'(rda0), 64'h11);

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      we  = $urandom_range(0, 1) == 1;
      wa  = 3'($urandom_range(0, 7));
      wd  = 8'($urandom);
      rea = $urandom_range(0, 3) != 0;
      reb = $urandom_range(0, 3) != 0;
      raa = ($urandom_range(0, 2) == 0) ? wa : 3'($urandom_range(0, 7));
      rab = ($urandom_range(0, 2) == 0) ? wa : 3'($urandom_range(0, 7));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
